time_set: RTL and testbench

TIME_SET -- requirements
Module: time_set

---
 rtl/time_pkg.sv | 41 ++++
 rtl/btn_edge.sv | 19 +
 rtl/time_set.sv | 157 +++++++++++++++
 tb/tb_time_set.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/time_pkg.sv
// Shared types and constants for the clock time-setting block: FSM states,
// BCD digit type, field widths, digit limits and binary/BCD helpers.
package time_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EDIT_HT,
      ST_EDIT_HU,
      ST_EDIT_MT,
      ST_EDIT_MU,
      ST_COMMIT
   } state_t;

   typedef logic [3:0] bcd_t;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;

   localparam bcd_t HT_MAX    = 4'd2;
   localparam bcd_t HU_MAX    = 4'd9;
   localparam bcd_t HU_MAX_20 = 4'd3;   // units limit once the hour is 20..23
   localparam bcd_t MT_MAX    = 4'd5;
   localparam bcd_t MU_MAX    = 4'd9;

   // Two-digit binary (0..99) to {tens, units} BCD
   function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
      bcd_t t;
      bcd_t u;
      t = 4'd0;
      for (int i = 1; i <= 9; i++) begin
         if (v >= 7'(i * 10)) t = 4'(i);
      end
      u = 4'(v - 7'(t) * 7'd10);
      return {t, u};
   endfunction

   function automatic logic [6:0] bcd_to_bin(input bcd_t t, input bcd_t u);
      return 7'(t) * 7'd10 + 7'(u);
   endfunction

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector for one debounced, synchronised button level.
module btn_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic rise
);

   logic btn_q;

   // btn_q clears on reset so a button held through reset release yields an edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) btn_q <= 1'b0;
      else        btn_q <= btn;
   end

   assign rise = btn & ~btn_q;

endmodule

// File: rtl/time_set.sv
// Hours/minutes editor driven by mode/next/inc buttons with inactivity timeout.
// Optional digit blinking is built when TIME_SET_BLINK_EN is defined.
module time_set import time_pkg::*; #(
   parameter int INIT_TIMEOUT_S = 30
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tick_1hz,
   input  logic              tick_2hz,
   input  logic              btn_mode,
   input  logic              btn_next,
   input  logic              btn_inc,
   input  logic [HOUR_W-1:0] cur_hour,
   input  logic [MIN_W-1:0]  cur_min,
   output logic              edit_active,
   output logic [1:0]        sel,
   output logic [3:0]        Ht,
   output logic [3:0]        Hu,
   output logic [3:0]        Mt,
   output logic [3:0]        Mu,
   output logic              load,
   output logic [HOUR_W-1:0] load_hour,
   output logic [MIN_W-1:0]  load_min,
   output logic [3:0]        blink_mask
);

   localparam int TO_W = (INIT_TIMEOUT_S > 1) ? $clog2(INIT_TIMEOUT_S) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(INIT_TIMEOUT_S - 1);

   state_t            state_reg;
   bcd_t              ht_reg, hu_reg, mt_reg, mu_reg;
   logic              load_reg;
   logic [HOUR_W-1:0] load_hour_reg;
   logic [MIN_W-1:0]  load_min_reg;
   logic [TO_W-1:0]   timeout_reg;
   logic              mode_e, next_e, inc_e;
   logic [7:0]        cur_hour_bcd, cur_min_bcd;
   bcd_t              hu_lim;

   btn_edge u_mode (.clk(clk), .rst_n(rst_n), .btn(btn_mode), .rise(mode_e));
   btn_edge u_next (.clk(clk), .rst_n(rst_n), .btn(btn_next), .rise(next_e));
   btn_edge u_inc  (.clk(clk), .rst_n(rst_n), .btn(btn_inc),  .rise(inc_e));

   assign cur_hour_bcd = bin_to_bcd(7'(cur_hour));
   assign cur_min_bcd  = bin_to_bcd(7'(cur_min));
   assign hu_lim       = (ht_reg == HT_MAX) ? HU_MAX_20 : HU_MAX;

   // Priority within edit states: mode, then next, then inc, then timeout tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         ht_reg        <= 4'd0;
         hu_reg        <= 4'd0;
         mt_reg        <= 4'd0;
         mu_reg        <= 4'd0;
         load_reg      <= 1'b0;
         load_hour_reg <= '0;
         load_min_reg  <= '0;
         timeout_reg   <= '0;
      end else begin
         load_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               timeout_reg <= '0;
               if (mode_e) begin
                  {ht_reg, hu_reg} <= cur_hour_bcd;
                  {mt_reg, mu_reg} <= cur_min_bcd;
                  state_reg        <= ST_EDIT_HT;
               end
            end
            ST_COMMIT: begin
               timeout_reg <= '0;
               state_reg   <= ST_IDLE;
            end
            default: begin
               if (mode_e) begin
                  timeout_reg   <= '0;
                  state_reg     <= ST_COMMIT;
                  load_reg      <= 1'b1;
                  load_hour_reg <= HOUR_W'(bcd_to_bin(ht_reg, hu_reg));
                  load_min_reg  <= MIN_W'(bcd_to_bin(mt_reg, mu_reg));
               end else if (next_e) begin
                  timeout_reg <= '0;
                  case (state_reg)
                     ST_EDIT_HT: state_reg <= ST_EDIT_HU;
                     ST_EDIT_HU: state_reg <= ST_EDIT_MT;
                     ST_EDIT_MT: state_reg <= ST_EDIT_MU;
                     default:    state_reg <= ST_EDIT_HT;
                  endcase
               end else if (inc_e) begin
                  timeout_reg <= '0;
                  case (state_reg)
                     ST_EDIT_HT: begin
                        if (ht_reg >= HT_MAX) begin
                           ht_reg <= 4'd0;
                        end else begin
                           ht_reg <= ht_reg + 4'd1;
                           if (ht_reg == HT_MAX - 4'd1 && hu_reg > HU_MAX_20) hu_reg <= HU_MAX_20;
                        end
                     end
                     ST_EDIT_HU: hu_reg <= (hu_reg >= hu_lim) ? 4'd0 : hu_reg + 4'd1;
                     ST_EDIT_MT: mt_reg <= (mt_reg >= MT_MAX) ? 4'd0 : mt_reg + 4'd1;
                     default:    mu_reg <= (mu_reg >= MU_MAX) ? 4'd0 : mu_reg + 4'd1;
                  endcase
               end else if (tick_1hz) begin
                  if (timeout_reg == TO_LAST) begin
                     timeout_reg <= '0;
                     state_reg   <= ST_IDLE;
                  end else begin
                     timeout_reg <= timeout_reg + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      sel         = 2'd0;
      edit_active = 1'b1;
      case (state_reg)
         ST_EDIT_HT: sel = 2'd0;
         ST_EDIT_HU: sel = 2'd1;
         ST_EDIT_MT: sel = 2'd2;
         ST_EDIT_MU: sel = 2'd3;
         default:    edit_active = 1'b0;
      endcase
   end

   // While idle the display follows the live time rather than stale edit digits
   assign Ht = (state_reg == ST_IDLE) ? cur_hour_bcd[7:4] : ht_reg;
   assign Hu = (state_reg == ST_IDLE) ? cur_hour_bcd[3:0] : hu_reg;
   assign Mt = (state_reg == ST_IDLE) ? cur_min_bcd[7:4]  : mt_reg;
   assign Mu = (state_reg == ST_IDLE) ? cur_min_bcd[3:0]  : mu_reg;

   assign load      = load_reg;
   assign load_hour = load_hour_reg;
   assign load_min  = load_min_reg;

`ifdef TIME_SET_BLINK_EN
   logic phase_reg;

   // Phase restarts at 0 on every edit session so the digit is visible first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            phase_reg <= 1'b0;
      else if (!edit_active) phase_reg <= 1'b0;
      else if (tick_2hz)     phase_reg <= ~phase_reg;
   end

   assign blink_mask = phase_reg ? (4'b0001 << sel) : 4'b0000;
`else
   logic unused_tick_2hz;
   assign unused_tick_2hz = tick_2hz;
   assign blink_mask      = 4'b0000;
`endif

endmodule

// File: tb/tb_time_set.sv
// Directed self-checking bench for time_set (timeout parameter set to 3 s).
module tb_time_set;
   import time_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              tick_1hz = 1'b0, tick_2hz = 1'b0;
   logic              btn_mode = 1'b0, btn_next = 1'b0, btn_inc = 1'b0;
   logic [HOUR_W-1:0] cur_hour = 5'd13;
   logic [MIN_W-1:0]  cur_min = 6'd47;
   logic              edit_active, load;
   logic [1:0]        sel;
   logic [3:0]        ht, hu, mt, mu, blink_mask;
   logic [HOUR_W-1:0] load_hour;
   logic [MIN_W-1:0]  load_min;

   int n_checks = 0;
   int n_fail   = 0;
   int load_count = 0;

   time_set #(.INIT_TIMEOUT_S(3)) dut (
      .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
      .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
      .cur_hour(cur_hour), .cur_min(cur_min),
      .edit_active(edit_active), .sel(sel),
      .Ht(ht), .Hu(hu), .Mt(mt), .Mu(mu),
      .load(load), .load_hour(load_hour), .load_min(load_min),
      .blink_mask(blink_mask)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (load) load_count++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s = %0d", tag, got);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // which: 0=mode 1=next 2=inc; outputs are checked by the caller after the press
   task automatic press(input int which);
      $display("press %0d", which);
      case (which)
         0: btn_mode = 1'b1;
         1: btn_next = 1'b1;
         default: btn_inc = 1'b1;
      endcase
      cyc();
      btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
      cyc();
   endtask

   task automatic tick1();
      tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0; cyc();
   endtask

   task automatic tick2();
      tick_2hz = 1'b1; cyc(); tick_2hz = 1'b0; cyc();
   endtask

   initial begin
      // reset state, idle display tracks 13:47
      #2;
      check("rst_edit", edit_active, 0);
      check("rst_load", load, 0);
      check("rst_sel", sel, 0);
      check("idle_hm", {ht, hu, mt, mu}, 32'h1347);
      cyc(); rst_n = 1'b1; cyc();

      // enter edit
      btn_mode = 1'b1; cyc();
      check("enter_edit", edit_active, 1);
      check("enter_digits", {ht, hu, mt, mu}, 32'h1347);
      check("enter_sel", sel, 0);
      btn_mode = 1'b0; cyc();
      cur_hour = 5'd5; cur_min = 6'd0; #1;
      check("held_digits", {ht, hu, mt, mu}, 32'h1347);

      // Ht increments: 13 -> 23 -> 03
      press(2); check("ht_inc_2", {ht, hu}, 32'h23);
      press(2); check("ht_wrap_0", {ht, hu}, 32'h03);

      // build 23:59 and commit
      press(2); press(2); check("ht_to_23", {ht, hu}, 32'h23);
      press(1); check("sel_hu", sel, 1);
      press(1); check("sel_mt", sel, 2);
      press(2); press(1); check("sel_mu", sel, 3);
      press(2); press(2); check("min_59", {mt, mu}, 32'h59);
      btn_mode = 1'b1; cyc();
      check("commit_load", load, 1);
      check("commit_hour", load_hour, 23);
      check("commit_min", load_min, 59);
      check("commit_edit", edit_active, 0);
      btn_mode = 1'b0; cyc();
      check("post_load", load, 0);
      check("post_edit", edit_active, 0);
      check("post_idle_hm", {ht, hu, mt, mu}, 32'h0500);
      check("load_once", load_count, 1);

      // 19:30 -> inc Ht clamps Hu to 3; Hu wraps 3 -> 0 at Ht=2
      cur_hour = 5'd19; cur_min = 6'd30;
      press(0); check("enter_19", {ht, hu}, 32'h19);
      press(2); check("clamp_hu", {ht, hu}, 32'h23);
      press(1); press(2); check("hu_wrap_20", {ht, hu}, 32'h20);

      // simultaneous mode/next/inc: commit only, digits unchanged
      btn_mode = 1'b1; btn_next = 1'b1; btn_inc = 1'b1; cyc();
      check("simul_load", load, 1);
      check("simul_digits", {ht, hu, mt, mu}, 32'h2030);
      check("simul_hour", load_hour, 20);
      check("simul_min", load_min, 30);
      btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0; cyc();
      check("simul_idle", edit_active, 0);

      // a held level gives one edge only
      btn_mode = 1'b1; cyc(); cyc(); cyc();
      check("hold_edit", edit_active, 1);
      check("hold_noload", load_count, 2);
      btn_mode = 1'b0; cyc();

      // timeout: an edge restarts the count
      tick1(); tick1();
      press(1);
      tick1(); tick1();
      check("to_pending", edit_active, 1);
      tick1();
      check("to_idle", edit_active, 0);
      check("to_noload", load_count, 2);

      // reset mid-edit in EDIT_MT
      press(0); press(1); press(1);
      check("mt_sel", sel, 2);
      press(2); check("mt_inc", mt, 4);
      rst_n = 1'b0; #1;
      check("rst_mid_edit", edit_active, 0);
      check("rst_mid_sel", sel, 0);
      check("rst_mid_mt", mt, 3);
      check("rst_mid_lhour", load_hour, 0);
      check("rst_mid_lmin", load_min, 0);
      btn_mode = 1'b1; cyc(); rst_n = 1'b1; cyc();
      check("held_thru_rst", edit_active, 1);
      check("recapture_mt", mt, 3);
      btn_mode = 1'b0; cyc();

      // blink phase in EDIT_HU
      press(1);
      check("blink_start", blink_mask, 0);
      tick2();
`ifdef TIME_SET_BLINK_EN
      check("blink_on", blink_mask, 4'b0010);
`else
      check("blink_off", blink_mask, 4'b0000);
`endif
      tick2();
      check("blink_back", blink_mask, 0);
      check("load_total", load_count, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
